uart_tx_serializer: RTL and testbench

Transmit engine for the UART core that sits directly downstream of the 128x8 transmit FIFO. It pops bytes from the FIFO when it is non-empty and serialises each byte onto the `tx` line. Each frame has a start bit, 7 or 8 data bits (LSB first), optional parity and one stop bit. Bit timing comes from the shared 16x baud enable, so the block runs entirely on the system clock.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer_if.sv | 12 +
 rtl/uart_bit_timer.sv | 47 ++++
 rtl/uart_tx_serializer.sv | 128 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, framing constants and a parity
// helper that the receiver also uses.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT1,
        ST_WAIT2,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Parity bit for a whole character; bit 7 is excluded in 7-bit mode.
    function automatic logic parity_of(input logic [7:0] data,
                                       input logic       bit8,
                                       input logic       odd_n_even);
        logic [7:0] masked;
        masked = bit8 ? data : {1'b0, data[6:0]};
        return (^masked) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Pop interface between the transmit FIFO and the serializer.
interface uart_tx_serializer_if;
    import uart_pkg::*;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read_n;

    modport master (input fifo_empty, input fifo_data, output fifo_read_n);
    modport slave  (output fifo_empty, output fifo_data, input fifo_read_n);

endinterface

// File: rtl/uart_bit_timer.sv
// Baud-tick counter and data-bit counter for the transmit engine.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    input  logic baud_en,
    input  logic count_bits,
    input  logic bit8,
    output logic bit_done,
    output logic last_bit
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    assign bit_done = run & baud_en & (tick_q == TICK_LAST);
    assign last_bit = (bit_cnt_q == (bit8 ? 3'd7 : 3'd6));

    always_comb begin
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        if (clear) begin
            tick_d    = '0;
            bit_cnt_d = '0;
        end else if (run && baud_en) begin
            tick_d = bit_done ? 4'd0 : tick_q + 4'd1;
            if (bit_done && count_bits)
                bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tick_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from the TX FIFO and shifts them out as
// start / 7-8 data / optional parity / stop frames on the 16x baud enable.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_W     = uart_pkg::DATA_W
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        baud_en,
    input  logic                        bit8,
    input  logic                        parity_en,
    input  logic                        odd_n_even,
    uart_tx_serializer_if.master        fifo,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        txrdy
);
    import uart_pkg::*;

    // state  | meaning
    // IDLE   | line high, waiting for FIFO data; POP | one-cycle read strobe
    // WAIT1/2| FIFO read latency; START/DATA/PARITY/STOP | one bit time each

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              bit8_q, bit8_d;
    logic              par_en_q, par_en_d;
    logic              tx_q, tx_d;
    logic              rd_n_q, rd_n_d;
    logic              busy_q, busy_d;
    logic              tmr_clear, tmr_run, bit_done, last_bit;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (tmr_clear),
        .run        (tmr_run),
        .baud_en    (baud_en),
        .count_bits (state_q == ST_DATA),
        .bit8       (bit8_q),
        .bit_done   (bit_done),
        .last_bit   (last_bit)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit8_d    = bit8_q;
        par_en_d  = par_en_q;
        tmr_clear = 1'b0;
        tmr_run   = 1'b0;
        case (state_q)
            ST_IDLE:  if (!fifo.fifo_empty) state_d = ST_POP;
            ST_POP:   state_d = ST_WAIT1;
            ST_WAIT1: state_d = ST_WAIT2;
            ST_WAIT2: begin
                // Frame format is frozen here so mid-frame changes are ignored.
                state_d   = ST_START;
                shreg_d   = fifo.fifo_data;
                par_d     = odd_n_even;
                bit8_d    = bit8;
                par_en_d  = parity_en;
                tmr_clear = 1'b1;
            end
            ST_START: begin
                tmr_run = 1'b1;
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                tmr_run = 1'b1;
                if (bit_done) begin
                    par_d   = par_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tmr_run = 1'b1;
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                tmr_run = 1'b1;
                if (bit_done) state_d = fifo.fifo_empty ? ST_IDLE : ST_POP;
            end
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with entry.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        rd_n_d = (state_d != ST_POP);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            bit8_q   <= 1'b0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            bit8_q   <= bit8_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            rd_n_q   <= rd_n_d;
            busy_q   <= busy_d;
        end
    end

    assign tx               = tx_q;
    assign tx_busy          = busy_q;
    assign txrdy            = ~busy_q;
    assign fifo.fifo_read_n = rd_n_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds the DUT, the
// stimulus pushes expected frames, and a line monitor decodes tx and compares.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic clock = 1'b0;
    logic reset_n, baud_en, bit8, parity_en, odd_n_even;
    logic tx, tx_busy, txrdy;

    uart_tx_serializer_if fifo_if();

    uart_tx_serializer #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_en    (baud_en),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .fifo       (fifo_if),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .txrdy      (txrdy)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        logic [7:0]  data;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] fifo_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pops = 0;
    int pop_edge = -100;
    int aborts = 0;
    int gap_checks = 0;
    bit in_frame = 1'b0;
    int bit_idx = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop.
    function automatic frame_t make_frame(input logic [7:0] b, input logic b8,
                                          input logic pe, input logic odd);
        frame_t f;
        int n = b8 ? 8 : 7;
        int ones = 0;
        f.bits = '0;
        f.data = b;
        f.nbits = 1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[f.nbits] = b[i];
            if (b[i]) ones++;
            f.nbits++;
        end
        if (pe) begin
            f.bits[f.nbits] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            f.nbits++;
        end
        f.bits[f.nbits] = 1'b1;
        f.nbits++;
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(make_frame(b, bit8, parity_en, odd_n_even));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || in_frame || tx_busy !== 1'b0)
               && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_in_budget", int'(n < budget), 1);
        if (n >= budget) begin
            exp_q.delete();
            fifo_q.delete();
        end
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        int bdiv = 0;
        baud_en = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bdiv = (bdiv + 1) % 4;
            baud_en = (bdiv == 0);
        end
    end

    // FIFO model with a two-cycle registered read latency.
    initial begin
        logic [7:0] d;
        fifo_if.fifo_empty = 1'b1;
        fifo_if.fifo_data  = 8'h00;
        forever begin
            @(posedge clock);
            #2;
            if (fifo_if.fifo_read_n === 1'b0) begin
                pop_edge = cyc;
                pops++;
                check("pop_while_nonempty", int'(fifo_q.size() > 0), 1);
                d = 8'h00;
                if (fifo_q.size() > 0) d = fifo_q.pop_front();
                fifo_if.fifo_empty = (fifo_q.size() == 0);
                @(posedge clock);
                #2;
                check("read_n_one_cycle", fifo_if.fifo_read_n, 1);
                fifo_if.fifo_empty = (fifo_q.size() == 0);
                @(posedge clock);
                #2;
                fifo_if.fifo_data = d;
            end
            fifo_if.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: finds each start bit, samples every bit mid-way by baud ticks.
    initial begin
        int tk = 0;
        int start_edge = 0;
        int end_edge = 0;
        bit have_end = 1'b0;
        bit busy_dropped = 1'b1;
        bit end_pending = 1'b0;
        bit exp_busy = 1'b0;
        frame_t cur;
        cur.bits = '0;
        cur.nbits = 0;
        cur.data = 8'h00;
        forever begin
            @(negedge clock);
            if (end_pending) begin
                check("busy_after_stop", tx_busy, exp_busy);
                end_pending = 1'b0;
            end
            if (!in_frame && tx_busy === 1'b0) busy_dropped = 1'b1;
            if (!in_frame && reset_n === 1'b1 && tx === 1'b0) begin
                start_edge = cyc;
                check("pop_to_start", start_edge - pop_edge, 3);
                if (have_end && !busy_dropped) begin
                    gap_checks++;
                    check("stop_to_start_gap", start_edge - end_edge, 3);
                end
                check("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    bit_idx = 0;
                    tk = 0;
                    busy_dropped = 1'b0;
                end
            end
            if (in_frame) begin
                if (tx_busy !== 1'b1) begin
                    aborts++;
                    in_frame = 1'b0;
                    have_end = 1'b0;
                    busy_dropped = 1'b1;
                end else if (baud_en === 1'b1) begin
                    if (tk == OS / 2) begin
                        check($sformatf("frame_%02h_bit%0d", cur.data, bit_idx), tx, cur.bits[bit_idx]);
                        if (bit_idx == 0) check("txrdy_low_in_frame", txrdy, 0);
                    end
                    tk++;
                    if (tk == OS) begin
                        tk = 0;
                        bit_idx++;
                        if (bit_idx == cur.nbits) begin
                            in_frame = 1'b0;
                            have_end = 1'b1;
                            end_edge = cyc + 1;
                            exp_busy = !fifo_if.fifo_empty;
                            end_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, g0, a0, n, lows, rds;
        reset_n    = 1'b0;
        bit8       = 1'b1;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;

        // Reset with 0xA5 already queued; 8N1.
        repeat (3) @(posedge clock);
        #1;
        push_byte(8'hA5);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_tx", tx, 1);
        check("reset_read_n", fifo_if.fifo_read_n, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_txrdy", txrdy, 1);
        check("reset_no_pop", pops, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        p0 = pops;
        wait_done(2000);
        check("a5_pop_count", pops - p0, 1);

        // 0x55 with even then odd parity.
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        push_byte(8'h55);
        wait_done(2000);
        odd_n_even = 1'b1;
        push_byte(8'h55);
        wait_done(2000);

        // 7-bit mode drops bit 7.
        bit8 = 1'b0;
        parity_en = 1'b0;
        push_byte(8'hFF);
        wait_done(2000);

        // Back-to-back frames.
        bit8 = 1'b1;
        p0 = pops;
        g0 = gap_checks;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_done(4000);
        check("b2b_pop_count", pops - p0, 3);
        check("b2b_gaps_no_idle", gap_checks - g0, 2);

        // Format change mid-frame must not affect the frame in flight.
        parity_en = 1'b1;
        odd_n_even = 1'b0;
        push_byte(8'h3C);
        n = 0;
        while (tx_busy !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        repeat (200) @(posedge clock);
        #1;
        bit8 = 1'b0;
        parity_en = 1'b0;
        odd_n_even = 1'b1;
        wait_done(2000);

        // Randomized formats and bursts.
        for (int r = 0; r < 10; r++) begin
            int nb;
            bit8       = 1'($urandom_range(0, 1));
            parity_en  = 1'($urandom_range(0, 1));
            odd_n_even = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) push_byte(8'($urandom));
            wait_done(1000 * nb + 500);
        end

        // Reset in the middle of DATA for 0x0F.
        bit8 = 1'b1;
        parity_en = 1'b0;
        push_byte(8'h0F);
        n = 0;
        while (!(in_frame && bit_idx >= 3) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("reached_data_bits", int'(n < 3000), 1);
        a0 = aborts;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_tx_busy", tx_busy, 0);
        check("midreset_txrdy", txrdy, 1);
        reset_n = 1'b1;
        p0 = pops;
        repeat (5) @(negedge clock);
        check("midreset_frame_abandoned", aborts - a0, 1);

        // Empty FIFO: line stays idle, no pops.
        lows = 0;
        rds = 0;
        repeat (1000) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
            if (fifo_if.fifo_read_n !== 1'b1) rds++;
        end
        check("idle_tx_low_cycles", lows, 0);
        check("idle_read_n_low_cycles", rds, 0);
        check("idle_no_pop", pops - p0, 0);
        check("no_pending_frames", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
